cpu_run_ctrl: RTL

Synthesisable run-control block for the 8-bit CPU family. It replaces testbench-only reset sequencing and timeout logic with hardware that can also be used in simulation.
- Drives the CPU reset and a clock enable.
- Detects HLT.
- Enforces a programmable cycle watchdog.
- Adds single-step and NUM_BP-channel PC breakpoint modes.
- Sits between the system clock/reset and cpu_top. The CPU advances only on edges where cpu_en=1.

---
 rtl/cpu_run_pkg.sv | 26 ++
 rtl/cpu_run_ctrl_bp_match.sv | 25 ++
 rtl/cpu_run_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types for the 8-bit CPU run-control block: FSM state encoding,
// launch-mode constants and a small state-classification helper.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_STEP    = 3'd4,
    ST_HALTED  = 3'd5,
    ST_TIMEOUT = 3'd6
  } run_state_e;

  typedef logic [1:0] run_mode_t;

  localparam run_mode_t MODE_RUN    = 2'd0;
  localparam run_mode_t MODE_STEP   = 2'd1;
  localparam run_mode_t MODE_RUN_BP = 2'd2;

  // States from which a start pulse performs a full relaunch.
  function automatic logic is_launch_state(input run_state_e s);
    return (s == ST_IDLE) || (s == ST_HALTED) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_bp_match.sv
// Combinational PC breakpoint comparator: one enable/address pair per channel,
// producing the per-channel hit vector and its OR-reduction.
module cpu_bp_match
  import cpu_run_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int NUM_BP = 2
) (
  input  logic [NUM_BP-1:0]      bp_en_i,
  input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
  input  logic [PC_W-1:0]        pc_i,
  output logic [NUM_BP-1:0]      hit_o,
  output logic                   any_hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit_o[i] = bp_en_i[i] && (bp_addr_i[i*PC_W +: PC_W] == pc_i);
    end
  end

  assign any_hit_o = |hit_o;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control FSM for the 8-bit CPU: reset sequencing, clock enable, HLT
// detection, cycle watchdog, single-step and PC breakpoints.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int NUM_BP     = 2,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic                   step_req,
  input  logic [CNT_W-1:0]       timeout_lim,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0]        pc,
  input  logic                   halted_in,
  output logic                   cpu_rst,
  output logic                   cpu_en,
  output logic [2:0]             state,
  output logic                   done,
  output logic                   timeout,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e        state_q, state_d;
  run_mode_t         mode_q, mode_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              sup_q, sup_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_BP-1:0] hit_vec;
  logic              any_hit;
  logic              active, ex_halt, ex_to, ex_bp, bp_sup, launch;

  cpu_bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .bp_en_i   (bp_en),
    .bp_addr_i (bp_addr),
    .pc_i      (pc),
    .hit_o     (hit_vec),
    .any_hit_o (any_hit)
  );

  // Exit conditions gate cpu_en in the same cycle they are seen.
  always_comb begin
    active  = (state_q == ST_RUN) || (state_q == ST_STEP);
    bp_sup  = (state_q == ST_STEP) || sup_q;
    ex_halt = active && halted_in;
    ex_to   = active && (timeout_lim != '0) && (cnt_q == timeout_lim);
    ex_bp   = active && (mode_q == MODE_RUN_BP) && any_hit && !bp_sup;
    cpu_en  = active && !(ex_halt || ex_to || ex_bp);
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rcnt_d   = rcnt_q;
    sup_d    = 1'b0;
    bp_hit_d = bp_hit_q;
    cnt_d    = (cpu_en && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    launch   = start && is_launch_state(state_q);

    if (abort) begin
      state_d  = ST_IDLE;
      bp_hit_d = '0;
      cnt_d    = '0;
    end else if (launch) begin
      state_d  = ST_RESET;
      mode_d   = mode;
      rcnt_d   = RC_W'(RST_CYCLES - 1);
      bp_hit_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (rcnt_q == '0) begin
            state_d = (mode_q == MODE_STEP) ? ST_PAUSE : ST_RUN;
          end else begin
            rcnt_d = rcnt_q - RC_W'(1);
          end
        end
        ST_RUN, ST_STEP: begin
          if (ex_halt) begin
            state_d = ST_HALTED;
          end else if (ex_to) begin
            state_d = ST_TIMEOUT;
          end else if (ex_bp) begin
            state_d  = ST_PAUSE;
            bp_hit_d = hit_vec;
          end else if (state_q == ST_STEP) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          // Resume keeps the launch mode; the first RUN cycle skips breakpoints
          // so the paused PC is not immediately re-hit.
          if (start) begin
            state_d  = ST_RUN;
            sup_d    = 1'b1;
            bp_hit_d = '0;
          end else if (step_req) begin
            state_d = ST_STEP;
          end
        end
        default: ;
      endcase
    end

    cpu_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    done_d    = (state_d == ST_HALTED);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_RUN;
      rcnt_q    <= '0;
      sup_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      bp_hit_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rcnt_q    <= rcnt_d;
      sup_q     <= sup_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      bp_hit_q  <= bp_hit_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state       = state_q;
  assign cpu_rst     = cpu_rst_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cnt_q;

endmodule
